// File: rtl/osd_ctrl_pkg.sv
// Shared types and constants for the OSD command sequencer.
package osd_ctrl_pkg;
  typedef enum logic [1:0] {OP_PUT, OP_SET_CUR, OP_CLEAR, OP_NEWLINE} osd_op_t;
  typedef enum logic {ST_IDLE, ST_CLEAR} osd_state_t;

  localparam logic [7:0] NULL_CHAR = 8'h00;
  localparam int         DEF_COLS  = 80;
  localparam int         DEF_ROWS  = 30;
endpackage

// File: rtl/osd_cursor.sv
// Text cursor register pair: clamped load, advance with line/screen wrap, newline.
// Also serves as the address counter for the clear sweep.
module osd_cursor #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [6:0] ld_x,
  input  logic [4:0] ld_y,
  input  logic       adv,
  input  logic       nl,
  input  logic       zero,
  output logic [6:0] x,
  output logic [4:0] y
);
  localparam logic [6:0] XMAX = 7'(COLS - 1);
  localparam logic [4:0] YMAX = 5'(ROWS - 1);

  logic [6:0] bx, nx;
  logic [4:0] by, ny;

  // zero+adv yields the position just after the origin (sweep start).
  always_comb begin
    bx = zero ? 7'd0 : x;
    by = zero ? 5'd0 : y;
    nx = x;
    ny = y;
    if (load) begin
      nx = (ld_x > XMAX) ? XMAX : ld_x;
      ny = (ld_y > YMAX) ? YMAX : ld_y;
    end else if (adv) begin
      if (bx == XMAX) begin
        nx = 7'd0;
        ny = (by == YMAX) ? 5'd0 : by + 5'd1;
      end else begin
        nx = bx + 7'd1;
        ny = by;
      end
    end else if (nl) begin
      nx = 7'd0;
      ny = (y == YMAX) ? 5'd0 : y + 5'd1;
    end else if (zero) begin
      nx = 7'd0;
      ny = 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x <= 7'd0;
      y <= 5'd0;
    end else begin
      x <= nx;
      y <= ny;
    end
  end
endmodule

// File: rtl/osd_ctrl.sv
// OSD command sequencer: turns PUT/SET_CUR/CLEAR/NEWLINE commands into
// single-cycle tile writes, and runs full-screen clears as a sweep.
module osd_ctrl
  import osd_ctrl_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [6:0] cmd_x,
  input  logic [4:0] cmd_y,
  input  logic [7:0] cmd_ch,
  output logic [6:0] xt,
  output logic [4:0] yt,
  output logic [7:0] ch_out,
  output logic       we_ch,
  output logic [6:0] cur_x,
  output logic [4:0] cur_y,
  output logic       busy
);
  localparam logic [6:0] XMAX = 7'(COLS - 1);
  localparam logic [4:0] YMAX = 5'(ROWS - 1);

  osd_state_t state, state_nxt;
  osd_op_t    op;
  logic       hs, last;
  logic       cur_ld, cur_adv, cur_nl, cur_zero;
  logic       wr_en;
  logic [6:0] wr_x;
  logic [4:0] wr_y;
  logic [7:0] wr_ch;

  assign op = osd_op_t'(cmd_op);
  assign hs = cmd_valid & cmd_ready;
  // The output register currently shows the final sweep tile.
  assign last = we_ch && (xt == XMAX) && (yt == YMAX);

  osd_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .clk   (clk),
    .reset (reset),
    .load  (cur_ld),
    .ld_x  (cmd_x),
    .ld_y  (cmd_y),
    .adv   (cur_adv),
    .nl    (cur_nl),
    .zero  (cur_zero),
    .x     (cur_x),
    .y     (cur_y)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (hs && op == OP_CLEAR) state_nxt = ST_CLEAR;
      ST_CLEAR: if (last) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == ST_IDLE);
    busy      = (state == ST_CLEAR);
    cur_ld    = 1'b0;
    cur_adv   = 1'b0;
    cur_nl    = 1'b0;
    cur_zero  = 1'b0;
    wr_en     = 1'b0;
    wr_x      = cur_x;
    wr_y      = cur_y;
    wr_ch     = NULL_CHAR;
    case (state)
      ST_IDLE: if (hs) begin
        case (op)
          OP_PUT: begin
            cur_adv = 1'b1;
            wr_en   = 1'b1;
            wr_ch   = cmd_ch;
          end
          OP_SET_CUR: cur_ld = 1'b1;
          OP_NEWLINE: cur_nl = 1'b1;
          OP_CLEAR: begin
            // First sweep tile is written straight from the handshake.
            cur_zero = 1'b1;
            cur_adv  = 1'b1;
            wr_en    = 1'b1;
            wr_x     = 7'd0;
            wr_y     = 5'd0;
          end
          default: ;
        endcase
      end
      ST_CLEAR: if (!last) begin
        cur_adv = 1'b1;
        wr_en   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_ch  <= 1'b0;
      xt     <= 7'd0;
      yt     <= 5'd0;
      ch_out <= 8'h00;
    end else begin
      we_ch <= wr_en;
      if (wr_en) begin
        xt     <= wr_x;
        yt     <= wr_y;
        ch_out <= wr_ch;
      end
    end
  end
endmodule

// File: tb/tb_osd_ctrl.sv
// Self-checking bench for osd_ctrl: directed scenarios plus random commands
// against a linear-address cursor model.
module tb_osd_ctrl;
  import osd_ctrl_pkg::*;

  localparam int C = 80;
  localparam int R = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [6:0] cmd_x = 7'd0;
  logic [4:0] cmd_y = 5'd0;
  logic [7:0] cmd_ch = 8'd0;
  logic [6:0] xt;
  logic [4:0] yt;
  logic [7:0] ch_out;
  logic       we_ch;
  logic [6:0] cur_x;
  logic [4:0] cur_y;
  logic       busy;

  osd_ctrl #(.COLS(C), .ROWS(R)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_ch(cmd_ch),
    .xt(xt), .yt(yt), .ch_out(ch_out), .we_ch(we_ch),
    .cur_x(cur_x), .cur_y(cur_y), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  int m_x = 0, m_y = 0, m_left = 0;
  bit m_busy = 0;
  bit e_we = 0;
  int e_x = 0, e_y = 0, e_ch = 0;

  // sweep observation
  int sw_cnt = 0, sw_oob = 0, sw_uniq = 0;
  bit seen [0:C*R-1];

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic sweep_reset();
    sw_cnt = 0; sw_oob = 0; sw_uniq = 0;
    for (int i = 0; i < C*R; i++) seen[i] = 1'b0;
  endtask

  // One clock: drive at negedge, update model, check at next negedge.
  task automatic cyc(input bit r, input bit v, input logic [1:0] op,
                     input int x, input int y, input int ch);
    bit hs;
    int lin;
    reset = r; cmd_valid = v; cmd_op = op;
    cmd_x = 7'(x); cmd_y = 5'(y); cmd_ch = 8'(ch);
    hs = v && !m_busy && !r;
    e_we = 0;
    if (r) begin
      m_x = 0; m_y = 0; m_left = 0; m_busy = 0;
    end else if (m_left > 0) begin
      lin = C*R - m_left;
      e_we = 1; e_x = lin % C; e_y = lin / C; e_ch = 0;
      m_left--;
    end else if (m_busy) begin
      m_busy = 0;
    end else if (hs) begin
      case (op)
        2'd0: begin
          e_we = 1; e_x = m_x; e_y = m_y; e_ch = ch;
          lin = (m_y*C + m_x + 1) % (C*R);
          m_x = lin % C; m_y = lin / C;
        end
        2'd1: begin
          m_x = (x > C-1) ? C-1 : x;
          m_y = (y > R-1) ? R-1 : y;
        end
        2'd2: begin
          e_we = 1; e_x = 0; e_y = 0; e_ch = 0;
          m_left = C*R - 1; m_busy = 1;
          m_x = 0; m_y = 0;
        end
        default: begin
          m_x = 0; m_y = (m_y + 1) % R;
        end
      endcase
    end
    @(posedge clk);
    @(negedge clk);
    chk("we_ch", we_ch, e_we);
    if (e_we) begin
      chk("xt", xt, e_x);
      chk("yt", yt, e_y);
      chk("ch_out", ch_out, e_ch);
    end
    chk("busy", busy, m_busy);
    chk("cmd_ready", cmd_ready, !m_busy);
    if (!m_busy) begin
      chk("cur_x", cur_x, m_x);
      chk("cur_y", cur_y, m_y);
    end
    if (busy && we_ch) begin
      sw_cnt++;
      if (xt >= C || yt >= R) sw_oob++;
      else if (!seen[yt*C + xt]) begin
        seen[yt*C + xt] = 1'b1;
        sw_uniq++;
      end
    end
  endtask

  initial begin
    int lowcnt;
    bit done;
    int rr;
    logic [1:0] rop;

    @(negedge clk);
    cyc(1, 1, 2'd0, 0, 0, 8'h77);
    cyc(1, 0, 2'd0, 0, 0, 0);
    chk("rst_xt", xt, 0);
    chk("rst_yt", yt, 0);
    chk("rst_ch", ch_out, 0);
    chk("rst_ready", cmd_ready, 1);

    cyc(0, 1, 2'd0, 0, 0, 8'h41);
    chk("put1_ch", ch_out, 8'h41);
    chk("put1_cur_x", cur_x, 1);

    cyc(0, 1, 2'd1, 79, 29, 0);
    cyc(0, 1, 2'd0, 0, 0, 8'hC2);
    chk("corner_xt", xt, 79);
    chk("corner_yt", yt, 29);
    chk("corner_wrap", {25'd0, cur_x, cur_y}, 0);

    cyc(0, 1, 2'd1, 120, 31, 0);
    chk("clamp_x", cur_x, 79);
    chk("clamp_y", cur_y, 29);
    cyc(0, 1, 2'd3, 0, 0, 0);
    chk("nl_wrap_y", cur_y, 0);
    cyc(0, 1, 2'd1, 5, 3, 0);
    cyc(0, 1, 2'd3, 0, 0, 0);
    chk("nl_x", cur_x, 0);
    chk("nl_y", cur_y, 4);

    cyc(0, 1, 2'd1, 78, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 2'd0, 0, 0, 8'h30 + i);
    chk("b2b_last_xt", xt, 0);
    chk("b2b_last_yt", yt, 1);

    // full clear with a PUT held valid behind it
    sweep_reset();
    cyc(0, 1, 2'd2, 0, 0, 0);
    lowcnt = 0; done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      if (!cmd_ready) lowcnt++;
      else done = 1;
      cyc(0, 1, 2'd0, 0, 0, 8'h55);
    end
    chk("clr_ready_low", lowcnt, C*R);
    chk("clr_writes", sw_cnt, C*R);
    chk("clr_unique", sw_uniq, C*R);
    chk("clr_oob", sw_oob, 0);
    chk("held_put_we", we_ch, 1);
    chk("held_put_xt", xt, 0);
    chk("held_put_yt", yt, 0);
    chk("held_put_ch", ch_out, 8'h55);

    // reset in the middle of a sweep
    cyc(0, 1, 2'd1, 10, 10, 0);
    sweep_reset();
    cyc(0, 1, 2'd2, 0, 0, 0);
    for (int i = 0; i < 1200 && sw_cnt < 1000; i++) cyc(0, 0, 2'd0, 0, 0, 0);
    chk("mid_reached", sw_cnt, 1000);
    cyc(1, 0, 2'd0, 0, 0, 0);
    chk("mid_we", we_ch, 0);
    chk("mid_busy", busy, 0);
    chk("mid_cur", {25'd0, cur_x, cur_y}, 0);
    cyc(0, 0, 2'd0, 0, 0, 0);
    chk("mid_ready", cmd_ready, 1);

    // random traffic
    for (int i = 0; i < 5000; i++) begin
      rr = $urandom_range(0, 399);
      rop = (rr == 0) ? 2'd2 : (rr < 240) ? 2'd0 : (rr < 320) ? 2'd1 : 2'd3;
      cyc(($urandom_range(0, 599) == 0), ($urandom_range(0, 9) < 7), rop,
          $urandom_range(0, 127), $urandom_range(0, 31), $urandom_range(0, 255));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/osd_ctrl.md
# osd_ctrl

Command sequencer for the on-screen-display text tile RAM. Accepts character, cursor and clear commands from the CPU-side register interface over a valid/ready handshake. Converts them into single-cycle tile writes on the OSD pixel source's write port (xt, yt, ch_in, we_ch). Owns the text cursor (auto-advance, line wrap, screen wrap) and runs full-screen clears as a multi-cycle sweep.

## Interface
Parameters:
- COLS, 80, visible text columns (≤128)
- ROWS, 30, visible text rows (≤32)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle when high with cmd_valid
- cmd_op  in  2  opcode: 0 PUT, 1 SET_CUR, 2 CLEAR, 3 NEWLINE
- cmd_x  in  7  column for SET_CUR
- cmd_y  in  5  row for SET_CUR
- cmd_ch  in  8  tile byte for PUT (bit 7 = reverse, bits 6:0 = ASCII)
- xt  out  7  tile column to OSD write port
- yt  out  5  tile row to OSD write port
- ch_out  out  8  tile byte to OSD write port (drives ch_in)
- we_ch  out  1  tile write strobe
- cur_x  out  7  current cursor column
- cur_y  out  5  current cursor row
- busy  out  1  high while a CLEAR sweep runs

## Operation
- FSM states IDLE, CLEAR. cmd_ready = (state == IDLE). Handshake = cmd_valid & cmd_ready.
- PUT: next cycle xt/yt = cursor, ch_out = cmd_ch, we_ch = 1 for one cycle. Cursor advances: x+1. At x = COLS-1, x→0 and y+1. At y = ROWS-1 with x = COLS-1, wraps to (0,0). No scrolling.
- SET_CUR: cursor ← (min(cmd_x, COLS-1), min(cmd_y, ROWS-1)). No write.
- NEWLINE: x→0, y→y+1, with ROWS-1→0. No write.
- CLEAR: enter CLEAR. Sweep row-major from (0,0) to (COLS-1, ROWS-1), one write per cycle with ch_out = 0x00 (NULL_CHAR, transparent), we_ch = 1 throughout. After the last write: cursor ← (0,0), return to IDLE.
- Tiles outside COLS×ROWS are never written.
- cmd_x/cmd_y/cmd_ch are sampled only on a handshake cycle.

## Timing
- All outputs are registered except cmd_ready and busy, which decode state.
- Reset values: xt=0, yt=0, ch_out=0, we_ch=0, cur_x=0, cur_y=0, busy=0, state IDLE (cmd_ready=1 in the first cycle after reset deasserts).
- Commands presented while reset is high are ignored.
- PUT latency: handshake at cycle N → we_ch high at N+1 with the pre-advance cursor. cur_x/cur_y show the advanced value at N+1.
- Back-to-back PUTs are accepted every cycle; we_ch stays high continuously with successive addresses.
- CLEAR: handshake at N; writes at N+1 … N+COLS·ROWS (2400 cycles at defaults). busy and !cmd_ready from N+1 through N+COLS·ROWS. cmd_ready returns at N+COLS·ROWS+1, with cursor (0,0) from that cycle.
- Reset mid-CLEAR: abort on the next edge. we_ch=0, IDLE, cursor (0,0). RAM is left partially cleared; the spec permits this.
- SET_CUR/NEWLINE take effect on cur_x/cur_y at N+1. A following PUT at N+1 uses the new cursor.

## Structure
- Package osd_ctrl_pkg: typedef enum logic[1:0] osd_op_t {OP_PUT, OP_SET_CUR, OP_CLEAR, OP_NEWLINE}. Constant NULL_CHAR = 8'h00. Defaults DEF_COLS = 80, DEF_ROWS = 30.
- Sub-module osd_cursor: the cursor register pair. Supports load (with clamp), advance-with-wrap and newline. It is reused by the CLEAR sweep as the sweep address counter, so the top holds only the FSM and output registers.

## Test plan
- Reset, then PUT 0x41 → cycle+1: we_ch=1, xt=0, yt=0, ch_out=0x41; cur=(1,0).
- SET_CUR (79,29), PUT 0xC2 → write at (79,29) with ch_out=0xC2; cursor wraps to (0,0).
- SET_CUR (120,31) → cursor clamps to (79,29). NEWLINE → (0,0). NEWLINE from (5,3) → (0,4).
- Three back-to-back PUTs from (78,0) → writes at (78,0), (79,0), (0,1) on consecutive cycles; we_ch never drops.
- CLEAR → exactly 2400 writes of 0x00, all addresses unique within 80×30, no writes with x≥80 or y≥30. cmd_ready low for 2400 cycles, PUT held valid accepted on the cycle ready returns and written at (0,0).
- Reset asserted at sweep write 1000 → next cycle we_ch=0, busy=0, cursor (0,0), cmd_ready=1 after deassert.
